// File: rtl/water_flow_monitor_if.sv
// Signal bundle between the drum water-flow monitor and its controller.
// The controller drives the master modport and the monitor uses the slave modport.
interface water_flow_monitor_if;
  logic       water_flow_reset;
  logic       water_flow_mode;
  logic [9:0] water_level_sensor;
  logic       water_flow_error;
  logic       fault_is_fill;
  logic       monitor_active;
  logic [2:0] stall_count;

  modport master (
    output water_flow_reset,
    output water_flow_mode,
    output water_level_sensor,
    input  water_flow_error,
    input  fault_is_fill,
    input  monitor_active,
    input  stall_count
  );

  modport slave (
    input  water_flow_reset,
    input  water_flow_mode,
    input  water_level_sensor,
    output water_flow_error,
    output fault_is_fill,
    output monitor_active,
    output stall_count
  );
endinterface

// File: rtl/water_flow_monitor.sv
// Watches the drum level while filling or draining and raises a sticky fault when
// the level stops moving for STALL_LIMIT consecutive samples.
module water_flow_monitor #(
  parameter int unsigned SAMPLE_CYCLES = 16,
  parameter int unsigned MIN_DELTA     = 2,
  parameter int unsigned STALL_LIMIT   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  water_flow_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MON_FILL  = 2'd1,
    MON_DRAIN = 2'd2,
    FAULT     = 2'd3
  } state_t;

  localparam logic [7:0]  LP_TICK_AT   = 8'(SAMPLE_CYCLES - 1);
  localparam logic [10:0] LP_MIN_DELTA = 11'(MIN_DELTA);
  localparam logic [2:0]  LP_LIMIT     = 3'(STALL_LIMIT);

  // Negative progress (level moved the wrong way) clamps to zero instead of wrapping.
  function automatic logic [10:0] progress_f(input logic       fill,
                                             input logic [9:0] level,
                                             input logic [9:0] base);
    logic [10:0] diff;
    if (fill) begin
      diff = {1'b0, level} - {1'b0, base};
    end else begin
      diff = {1'b0, base} - {1'b0, level};
    end
    if (diff[10]) begin
      return 11'd0;
    end else begin
      return diff;
    end
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [9:0]  r_base;
  logic [2:0]  r_stall;
  logic        r_err;
  logic        r_fault_fill;
  logic        r_active;

  state_t      w_state_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [9:0]  w_base_nxt;
  logic [2:0]  w_stall_nxt;
  logic        w_err_nxt;
  logic        w_fault_fill_nxt;
  logic        w_active_nxt;
  logic        w_fill;
  logic        w_tick;
  logic        w_progress;
  logic [10:0] w_delta;

  // Next-state, counter, baseline and output decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_base_nxt       = r_base;
    w_stall_nxt      = r_stall;
    w_fill           = (r_state == MON_FILL);
    w_tick           = (r_cnt == LP_TICK_AT);
    w_delta          = progress_f(w_fill, bus.water_level_sensor, r_base);
    w_progress       = (w_delta >= LP_MIN_DELTA) ||
                       ( w_fill && (bus.water_level_sensor == 10'd1023)) ||
                       (!w_fill && (bus.water_level_sensor == 10'd0));

    if (bus.water_flow_reset) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 8'd0;
      w_base_nxt  = 10'd0;
      w_stall_nxt = 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_base_nxt  = bus.water_level_sensor;
          w_cnt_nxt   = 8'd0;
          w_stall_nxt = 3'd0;
          w_state_nxt = bus.water_flow_mode ? MON_FILL : MON_DRAIN;
        end
        MON_FILL, MON_DRAIN: begin
          // A direction change restarts monitoring and outranks a coincident tick.
          if (bus.water_flow_mode != w_fill) begin
            w_state_nxt = bus.water_flow_mode ? MON_FILL : MON_DRAIN;
            w_base_nxt  = bus.water_level_sensor;
            w_cnt_nxt   = 8'd0;
            w_stall_nxt = 3'd0;
          end else if (w_tick) begin
            w_cnt_nxt  = 8'd0;
            w_base_nxt = bus.water_level_sensor;
            if (w_progress) begin
              w_stall_nxt = 3'd0;
            end else if (r_stall < LP_LIMIT) begin
              w_stall_nxt = r_stall + 3'd1;
              if ((r_stall + 3'd1) == LP_LIMIT) begin
                w_state_nxt = FAULT;
              end else begin
                w_state_nxt = r_state;
              end
            end else begin
              w_stall_nxt = LP_LIMIT;
              w_state_nxt = FAULT;
            end
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
          w_base_nxt  = 10'd0;
          w_stall_nxt = 3'd0;
        end
      endcase
    end

    w_err_nxt        = (w_state_nxt == FAULT);
    w_active_nxt     = (w_state_nxt == MON_FILL) || (w_state_nxt == MON_DRAIN);
    w_fault_fill_nxt = 1'b0;
    if (w_state_nxt == FAULT) begin
      w_fault_fill_nxt = (r_state == FAULT) ? r_fault_fill : (r_state == MON_FILL);
    end else begin
      w_fault_fill_nxt = 1'b0;
    end
  end

  // State and registered outputs; outputs are decoded from next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 8'd0;
      r_base       <= 10'd0;
      r_stall      <= 3'd0;
      r_err        <= 1'b0;
      r_fault_fill <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_base       <= w_base_nxt;
      r_stall      <= w_stall_nxt;
      r_err        <= w_err_nxt;
      r_fault_fill <= w_fault_fill_nxt;
      r_active     <= w_active_nxt;
    end
  end

  assign bus.water_flow_error = r_err;
  assign bus.fault_is_fill    = r_fault_fill;
  assign bus.monitor_active   = r_active;
  assign bus.stall_count      = r_stall;

endmodule

// File: tb/tb_water_flow_monitor.sv
// Directed bench for water_flow_monitor: a vector table for the main behaviour plus
// hand-written sequences for mode-change, reset and long-run corner cases.
module tb_water_flow_monitor;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  water_flow_monitor_if bus ();

  water_flow_monitor #(
    .SAMPLE_CYCLES(16),
    .MIN_DELTA    (2),
    .STALL_LIMIT  (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wfr;
    logic       mode;
    logic [9:0] lvl;
    logic [7:0] n;
    logic       err;
    logic       fif;
    logic       act;
    logic [2:0] stall;
  } vec_t;

  vec_t vecs [29];

  function automatic vec_t mk(input logic wfr, input logic mode, input logic [9:0] lvl,
                              input logic [7:0] n, input logic err, input logic fif,
                              input logic act, input logic [2:0] stall);
    vec_t v;
    v.wfr = wfr; v.mode = mode; v.lvl = lvl; v.n = n;
    v.err = err; v.fif = fif; v.act = act; v.stall = stall;
    return v;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic e, input logic f,
                     input logic a, input logic [2:0] s);
    logic [5:0] got;
    logic [5:0] exp;
    got = {bus.water_flow_error, bus.fault_is_fill, bus.monitor_active, bus.stall_count};
    exp = {e, f, a, s};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got err=%b fif=%b act=%b stall=%0d, expected err=%b fif=%b act=%b stall=%0d",
               nm, idx, got[5], got[4], got[3], got[2:0], e, f, a, s);
    end
  endtask

  task automatic drive(input logic wfr, input logic mode, input logic [9:0] lvl);
    bus.water_flow_reset   = wfr;
    bus.water_flow_mode    = mode;
    bus.water_level_sensor = lvl;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1, 10'd100);
    step(1);
    chk("reset", 0, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 1'b1, 10'd100,  8'd1,   1'b0, 1'b0, 1'b1, 3'd0);
    vecs[1]  = mk(1'b0, 1'b1, 10'd100,  8'd16,  1'b0, 1'b0, 1'b1, 3'd1);
    vecs[2]  = mk(1'b0, 1'b1, 10'd100,  8'd15,  1'b0, 1'b0, 1'b1, 3'd1);
    vecs[3]  = mk(1'b0, 1'b1, 10'd100,  8'd1,   1'b0, 1'b0, 1'b1, 3'd2);
    vecs[4]  = mk(1'b0, 1'b1, 10'd100,  8'd16,  1'b0, 1'b0, 1'b1, 3'd3);
    vecs[5]  = mk(1'b0, 1'b1, 10'd100,  8'd15,  1'b0, 1'b0, 1'b1, 3'd3);
    vecs[6]  = mk(1'b0, 1'b1, 10'd100,  8'd1,   1'b1, 1'b1, 1'b0, 3'd4);
    vecs[7]  = mk(1'b0, 1'b0, 10'd100,  8'd5,   1'b1, 1'b1, 1'b0, 3'd4);
    vecs[8]  = mk(1'b1, 1'b0, 10'd100,  8'd1,   1'b0, 1'b0, 1'b0, 3'd0);
    vecs[9]  = mk(1'b1, 1'b1, 10'd100,  8'd3,   1'b0, 1'b0, 1'b0, 3'd0);
    vecs[10] = mk(1'b0, 1'b1, 10'd100,  8'd1,   1'b0, 1'b0, 1'b1, 3'd0);
    vecs[11] = mk(1'b0, 1'b1, 10'd100,  8'd63,  1'b0, 1'b0, 1'b1, 3'd3);
    vecs[12] = mk(1'b0, 1'b1, 10'd100,  8'd1,   1'b1, 1'b1, 1'b0, 3'd4);
    vecs[13] = mk(1'b1, 1'b1, 10'd100,  8'd1,   1'b0, 1'b0, 1'b0, 3'd0);
    vecs[14] = mk(1'b0, 1'b0, 10'd500,  8'd1,   1'b0, 1'b0, 1'b1, 3'd0);
    vecs[15] = mk(1'b0, 1'b0, 10'd500,  8'd64,  1'b1, 1'b0, 1'b0, 3'd4);
    vecs[16] = mk(1'b1, 1'b0, 10'd500,  8'd1,   1'b0, 1'b0, 1'b0, 3'd0);
    vecs[17] = mk(1'b0, 1'b0, 10'd0,    8'd1,   1'b0, 1'b0, 1'b1, 3'd0);
    vecs[18] = mk(1'b0, 1'b0, 10'd0,    8'd200, 1'b0, 1'b0, 1'b1, 3'd0);
    vecs[19] = mk(1'b0, 1'b1, 10'd0,    8'd1,   1'b0, 1'b0, 1'b1, 3'd0);
    vecs[20] = mk(1'b0, 1'b1, 10'd0,    8'd16,  1'b0, 1'b0, 1'b1, 3'd1);
    vecs[21] = mk(1'b0, 1'b1, 10'd1023, 8'd16,  1'b0, 1'b0, 1'b1, 3'd0);
    vecs[22] = mk(1'b0, 1'b1, 10'd1023, 8'd16,  1'b0, 1'b0, 1'b1, 3'd0);
    vecs[23] = mk(1'b0, 1'b1, 10'd1022, 8'd16,  1'b0, 1'b0, 1'b1, 3'd1);
    vecs[24] = mk(1'b0, 1'b1, 10'd1023, 8'd16,  1'b0, 1'b0, 1'b1, 3'd0);
    vecs[25] = mk(1'b0, 1'b1, 10'd1,    8'd16,  1'b0, 1'b0, 1'b1, 3'd1);
    vecs[26] = mk(1'b0, 1'b1, 10'd3,    8'd16,  1'b0, 1'b0, 1'b1, 3'd0);
    vecs[27] = mk(1'b0, 1'b1, 10'd4,    8'd16,  1'b0, 1'b0, 1'b1, 3'd1);
    vecs[28] = mk(1'b1, 1'b1, 10'd4,    8'd1,   1'b0, 1'b0, 1'b0, 3'd0);

    reset = 1'b1;
    drive(1'b0, 1'b0, 10'd0);
    step(2);
    chk("reset", 0, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i].wfr, vecs[i].mode, vecs[i].lvl);
      step(int'(vecs[i].n));
      chk("vec", i, vecs[i].err, vecs[i].fif, vecs[i].act, vecs[i].stall);
    end

    // Mode flip to drain right after stall_count reaches 3: no fault, fresh count.
    do_reset();
    drive(1'b0, 1'b1, 10'd100);
    step(49);
    chk("flip_pre", 0, 1'b0, 1'b0, 1'b1, 3'd3);
    drive(1'b0, 1'b0, 10'd100);
    step(1);
    chk("flip_post", 0, 1'b0, 1'b0, 1'b1, 3'd0);
    step(63);
    chk("flip_drain", 0, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1);
    chk("flip_drain", 1, 1'b1, 1'b0, 1'b0, 3'd4);

    // Mode change on the tick edge suppresses the stall increment and restarts the counter.
    do_reset();
    drive(1'b0, 1'b1, 10'd100);
    step(16);
    chk("tick_flip", 0, 1'b0, 1'b0, 1'b1, 3'd0);
    drive(1'b0, 1'b0, 10'd100);
    step(1);
    chk("tick_flip", 1, 1'b0, 1'b0, 1'b1, 3'd0);
    step(15);
    chk("tick_flip", 2, 1'b0, 1'b0, 1'b1, 3'd0);
    step(1);
    chk("tick_flip", 3, 1'b0, 1'b0, 1'b1, 3'd1);

    // Reset in FAULT and in MON_FILL, with water_flow_reset held low.
    do_reset();
    drive(1'b0, 1'b1, 10'd100);
    step(65);
    chk("rst_fault", 0, 1'b1, 1'b1, 1'b0, 3'd4);
    reset = 1'b1;
    step(1);
    chk("rst_fault", 1, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    step(11);
    chk("rst_mon", 0, 1'b0, 1'b0, 1'b1, 3'd0);
    reset = 1'b1;
    step(1);
    chk("rst_mon", 1, 1'b0, 1'b0, 1'b0, 3'd0);
    reset = 1'b0;

    // Steady fill rising 3 per sample period never stalls.
    do_reset();
    drive(1'b0, 1'b1, 10'd100);
    step(1);
    for (int c = 0; c < 1000; c++) begin
      step(1);
      chk("steady_fill", c, 1'b0, 1'b0, 1'b1, 3'd0);
      if ((c % 16) == 7) begin
        bus.water_level_sensor = bus.water_level_sensor + 10'd3;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
